// File: rtl/br_fu_pipe_pkg.sv
// Shared types and constants for the branch functional unit pipeline.
package br_fu_pipe_pkg;

  localparam int ROB_IDX  = 5;
  localparam int PRF_IDX  = 6;
  localparam int XLEN     = 32;
  localparam int ARCH_IDX = 5;

  // Branch/jump opcodes as issued by the branch reservation station.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_JAL  = 3'd2,
    BR_JALR = 3'd3,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_op_e;

  // Issue-stage contents: everything needed to resolve the uop.
  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    br_op_e              opcode;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic                predict_taken;
    logic [XLEN-1:0]     predict_target;
    logic [XLEN-1:0]     rs1_value;
    logic [XLEN-1:0]     rs2_value;
  } br_s1_t;

  // Result-stage contents: exactly what is broadcast on the CDB and resolve bus.
  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    logic [XLEN-1:0]     rd_value;
    logic [XLEN-1:0]     pc;
    logic                taken;
    logic [XLEN-1:0]     target;
    logic                mispredict;
  } br_s2_t;

  // Unconditional jumps write a link value and are always taken.
  function automatic logic br_is_jump(input br_op_e op);
    return (op == BR_JAL) || (op == BR_JALR);
  endfunction

endpackage

// File: rtl/br_resolve_comb.sv
// Combinational branch resolution: direction compare, target, link value
// and mispredict detection for the uop held in the issue stage.
module br_resolve_comb
  import br_fu_pipe_pkg::*;
(
  input  br_s1_t s1,
  output br_s2_t res
);

  // JALR targets always have bit 0 cleared.
  localparam logic [XLEN-1:0] LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] INSN_BYTES = {{(XLEN-3){1'b0}}, 3'd4};

  logic            taken_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] pc_rel_s;
  logic [XLEN-1:0] jalr_s;
  logic [XLEN-1:0] dest_s;

  assign pc_plus4_s = s1.pc + INSN_BYTES;
  assign pc_rel_s   = s1.pc + s1.imm;
  assign jalr_s     = (s1.rs1_value + s1.imm) & LSB_CLR;

  // Direction: signed or unsigned compare per opcode, jumps always taken.
  always_comb begin
    taken_s = 1'b0;
    case (s1.opcode)
      BR_BEQ:  taken_s = (s1.rs1_value == s1.rs2_value);
      BR_BNE:  taken_s = (s1.rs1_value != s1.rs2_value);
      BR_BLT:  taken_s = ($signed(s1.rs1_value) <  $signed(s1.rs2_value));
      BR_BGE:  taken_s = ($signed(s1.rs1_value) >= $signed(s1.rs2_value));
      BR_BLTU: taken_s = (s1.rs1_value <  s1.rs2_value);
      BR_BGEU: taken_s = (s1.rs1_value >= s1.rs2_value);
      BR_JAL:  taken_s = 1'b1;
      BR_JALR: taken_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
  end

  // Taken destination: register-relative for JALR, PC-relative otherwise.
  always_comb begin
    dest_s = pc_rel_s;
    if (s1.opcode == BR_JALR) begin
      dest_s = jalr_s;
    end else begin
      dest_s = pc_rel_s;
    end
  end

  // Assemble the broadcast result, comparing against the frontend prediction.
  always_comb begin
    res            = '0;
    res.rob_id     = s1.rob_id;
    res.rd_phy     = s1.rd_phy;
    res.rd_arch    = s1.rd_arch;
    res.pc         = s1.pc;
    res.taken      = taken_s;
    res.target     = taken_s ? dest_s : pc_plus4_s;
    res.mispredict = (taken_s != s1.predict_taken) ||
                     (taken_s && (dest_s != s1.predict_target));
    if (br_is_jump(s1.opcode)) begin
      res.rd_value = pc_plus4_s;
    end else begin
      res.rd_value = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/br_fu_pipe.sv
// Two-stage branch functional unit: issue register (S1), resolution logic,
// result register (S2) driving the CDB and the branch-resolve bus.
module br_fu_pipe
  import br_fu_pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                br_rs_valid,
  output logic                fu_br_ready,
  input  logic [ROB_IDX-1:0]  in_rob_id,
  input  logic [PRF_IDX-1:0]  in_rd_phy,
  input  logic [4:0]          in_rd_arch,
  input  logic [2:0]          in_fu_opcode,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_predict_taken,
  input  logic [XLEN-1:0]     in_predict_target,
  input  logic [XLEN-1:0]     in_rs1_value,
  input  logic [XLEN-1:0]     in_rs2_value,
  input  logic                cdb_ready,
  output logic                cdb_valid,
  output logic [ROB_IDX-1:0]  cdb_rob_id,
  output logic [PRF_IDX-1:0]  cdb_rd_phy,
  output logic [4:0]          cdb_rd_arch,
  output logic [XLEN-1:0]     cdb_rd_value,
  output logic                br_valid,
  output logic [ROB_IDX-1:0]  br_rob_id,
  output logic [XLEN-1:0]     br_pc,
  output logic                br_taken,
  output logic [XLEN-1:0]     br_target,
  output logic                br_mispredict
);

  br_s1_t s1_in_s;
  br_s1_t s1_r;
  logic   s1_valid_r;
  br_s2_t s2_in_s;
  br_s2_t s2_r;
  logic   s2_valid_r;
  logic   s1_adv_s;
  logic   s2_adv_s;

  // S2 moves when empty or its entry is being taken by the CDB;
  // S1 moves when empty or S2 moves.
  assign s2_adv_s    = !s2_valid_r || cdb_ready;
  assign s1_adv_s    = !s1_valid_r || s2_adv_s;
  assign fu_br_ready = s1_adv_s && !flush;

  // Bundle the issue-port fields into the S1 record.
  always_comb begin
    s1_in_s                = '0;
    s1_in_s.rob_id         = in_rob_id;
    s1_in_s.rd_phy         = in_rd_phy;
    s1_in_s.rd_arch        = in_rd_arch;
    s1_in_s.opcode         = br_op_e'(in_fu_opcode);
    s1_in_s.imm            = in_imm;
    s1_in_s.pc             = in_pc;
    s1_in_s.predict_taken  = in_predict_taken;
    s1_in_s.predict_target = in_predict_target;
    s1_in_s.rs1_value      = in_rs1_value;
    s1_in_s.rs2_value      = in_rs2_value;
  end

  br_resolve_comb u_resolve (
    .s1  (s1_r),
    .res (s2_in_s)
  );

  // S1 issue register: flush wins over accept; payload only loads on a new uop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= br_rs_valid;
      if (br_rs_valid) begin
        s1_r <= s1_in_s;
      end
    end
  end

  // S2 result register: flush wins over retire; holds while the CDB stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_r       <= '0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_r <= s2_in_s;
      end
    end
  end

  // Broadcast straight from S2; valids are suppressed in a flush cycle.
  assign cdb_valid     = s2_valid_r && !flush;
  assign br_valid      = s2_valid_r && !flush;
  assign cdb_rob_id    = s2_r.rob_id;
  assign cdb_rd_phy    = s2_r.rd_phy;
  assign cdb_rd_arch   = s2_r.rd_arch;
  assign cdb_rd_value  = s2_r.rd_value;
  assign br_rob_id     = s2_r.rob_id;
  assign br_pc         = s2_r.pc;
  assign br_taken      = s2_r.taken;
  assign br_target     = s2_r.target;
  assign br_mispredict = s2_r.mispredict;

endmodule
